// File: rtl/sort_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : sort_loader_if
// Description : Valid/ready element stream feeding the sort loader.
//               The source drives in_valid/in_data, the loader drives in_ready.
// Revision    : 1.0 - initial release
// ============================================================================
interface sort_loader_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;

  modport master (output in_valid, output in_data, input  in_ready);
  modport slave  (input  in_valid, input  in_data, output in_ready);
endinterface
`default_nettype wire

// File: rtl/sort_loader.sv
`default_nettype none
// ============================================================================
// Module      : sort_loader
// Description : Writer side of the bitonic sort engine's input array. Packs
//               N streamed WIDTH-bit elements into a parallel array, strobes
//               the sorter's active-low load, issues one step pulse, waits for
//               sort_done (with timeout) and reports completion.
//               Optional feature macro: SORT_LOADER_PAD_EN (early commit with
//               all-ones padding of unwritten slots).
// Revision    : 1.0 - initial release
// ============================================================================
module sort_loader #(
  parameter int WIDTH   = 8,
  parameter int N       = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  sort_loader_if.slave              in_if,
  input  wire logic                 commit,
  input  wire logic                 clear,
  input  wire logic                 sort_done,
  output logic                      load_n,
  output logic                      start,
  output logic [N*WIDTH-1:0]        data_flat,
  output logic [IDX_W:0]            count,
  output logic                      done,
  output logic                      err
);

  localparam int             TMO_W  = $clog2(TIMEOUT + 1);
  localparam logic [IDX_W:0] C_FULL = (IDX_W+1)'(N);
  localparam logic [TMO_W-1:0] C_TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_KICK = 3'd2,
    S_WAIT = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   slot_q [N];
  logic [WIDTH-1:0]   slot_d [N];
  logic [IDX_W:0]     count_q, count_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               in_ready_q, in_ready_d;
  logic               load_n_q, load_n_d;
  logic               start_q, start_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               accept;

`ifndef SORT_LOADER_PAD_EN
  // Without padding support an early commit has no effect.
  logic unused_commit;
  assign unused_commit = commit;
`endif

  // Next-state, array update and registered-output computation.
  always_comb begin
    state_d    = state_q;
    slot_d     = slot_q;
    count_d    = count_q;
    tmo_d      = tmo_q;
    done_d     = done_q;
    err_d      = err_q;
    accept     = 1'b0;

    case (state_q)
      S_IDLE: begin
        accept = in_if.in_valid & in_ready_q;
        if (accept) begin
          for (int i = 0; i < N; i++) begin
            if (count_q == (IDX_W+1)'(i)) slot_d[i] = in_if.in_data;
          end
          count_d = count_q + (IDX_W+1)'(1);
        end
        // Commit is evaluated against the count that includes this cycle's beat.
        if (count_d == C_FULL) begin
          state_d = S_LOAD;
        end
`ifdef SORT_LOADER_PAD_EN
        else if (commit && (count_d != '0)) begin
          state_d = S_LOAD;
          for (int i = 0; i < N; i++) begin
            if ((IDX_W+1)'(i) >= count_d) slot_d[i] = {WIDTH{1'b1}};
          end
        end
`endif
      end
      S_LOAD: state_d = S_KICK;
      S_KICK: begin
        state_d = S_WAIT;
        tmo_d   = '0;
      end
      S_WAIT: begin
        if (sort_done) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
        end else if (tmo_q == C_TMO_LAST) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      S_DONE: begin
        if (clear) begin
          state_d = S_IDLE;
          for (int i = 0; i < N; i++) slot_d[i] = '0;
          count_d = '0;
          done_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they line up with it.
    in_ready_d = (state_d == S_IDLE);
    load_n_d   = (state_d != S_LOAD);
    start_d    = (state_d == S_KICK);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < N; i++) slot_q[i] <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      in_ready_q <= 1'b1;
      load_n_q   <= 1'b1;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_q     <= slot_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      in_ready_q <= in_ready_d;
      load_n_q   <= load_n_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  generate
    for (genvar g = 0; g < N; g++) begin : g_flat
      assign data_flat[g*WIDTH +: WIDTH] = slot_q[g];
    end
  endgenerate

  assign in_if.in_ready = in_ready_q;
  assign load_n         = load_n_q;
  assign start          = start_q;
  assign count          = count_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule
`default_nettype wire

// File: tb/tb_sort_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_sort_loader
// Description : Self-checking bench for sort_loader; scoreboard queue of
//               expected slot contents, one task per scenario.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sort_loader;
  localparam int WIDTH = 8;
  localparam int N     = 16;
  localparam int IDX_W = 4;
  localparam int TMO   = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic commit = 1'b0;
  logic clear = 1'b0;
  logic sort_done = 1'b0;
  logic load_n, start, done, err;
  logic [N*WIDTH-1:0] data_flat;
  logic [IDX_W:0]     count;

  int total = 0;
  int bad   = 0;
  logic [WIDTH-1:0] exp_q [$];

  sort_loader_if #(.WIDTH(WIDTH)) bus ();

  sort_loader #(.WIDTH(WIDTH), .N(N), .IDX_W(IDX_W), .TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_if     (bus),
    .commit    (commit),
    .clear     (clear),
    .sort_done (sort_done),
    .load_n    (load_n),
    .start     (start),
    .data_flat (data_flat),
    .count     (count),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] slot(input int i);
    return data_flat[i*WIDTH +: WIDTH];
  endfunction

  task automatic do_reset;
    rst = 1'b0;
    #2;
    rst = 1'b1;
    exp_q.delete();
    tick;
  endtask

  task automatic test_reset;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    #1 rst = 1'b0;
    tick;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_in_ready got=%b want=1", bus.in_ready); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL rst_load_n got=%b want=1", load_n); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rst_start got=%b want=0", start); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b want=0", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err got=%b want=0", err); end
    total++; if (count !== '0) begin bad++; $display("FAIL rst_count got=%0d want=0", count); end
    total++; if (data_flat !== '0) begin bad++; $display("FAIL rst_data got=%h want=0", data_flat); end
    rst = 1'b1;
    tick;
  endtask

  task automatic test_full_load;
    logic [7:0] vals [16] = '{8'd9, 8'd4, 8'd5, 8'd2, 8'd3, 8'd1, 8'd6, 8'd7,
                              8'd0, 8'd8, 8'd10, 8'd12, 8'd11, 8'd13, 8'd15, 8'd14};
    logic [WIDTH-1:0] e;
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.in_data = vals[i];
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL full_ready%0d got=%b want=1", i, bus.in_ready); end
      exp_q.push_back(vals[i]);
      tick;
    end
    bus.in_valid = 1'b0;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low got=%b want=0", bus.in_ready); end
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL full_load_n got=%b want=0", load_n); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL full_start_early got=%b want=0", start); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL full_count got=%0d want=16", count); end
    for (int i = 0; i < N; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      total++; if (slot(i) !== e) begin bad++; $display("FAIL full_slot%0d got=%h want=%h", i, slot(i), e); end
    end
    tick;
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL kick_load_n got=%b want=1", load_n); end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL kick_start got=%b want=1", start); end
    tick;
    total++; if (start !== 1'b0) begin bad++; $display("FAIL wait_start got=%b want=0", start); end
    repeat (4) begin
      tick;
      total++; if (done !== 1'b0) begin bad++; $display("FAIL early_done got=%b want=0", done); end
    end
    sort_done = 1'b1;
    tick;
    sort_done = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sd_done got=%b want=1", done); end
    total++; if (err !== 1'b0) begin bad++; $display("FAIL sd_err got=%b want=0", err); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL sd_count got=%0d want=16", count); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (done !== 1'b0) begin bad++; $display("FAIL clr_done got=%b want=0", done); end
    total++; if (count !== '0) begin bad++; $display("FAIL clr_count got=%0d want=0", count); end
    total++; if (data_flat !== '0) begin bad++; $display("FAIL clr_data got=%h want=0", data_flat); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL clr_ready got=%b want=1", bus.in_ready); end
  endtask

  task automatic test_gaps;
    int mcount = 0;
    int cyc    = 0;
    int v;
    logic [WIDTH-1:0] e;
    while (mcount < N && cyc < 300) begin
      v = $urandom_range(0, 1);
      bus.in_valid = v[0];
      bus.in_data  = v[0] ? 8'(100 + mcount) : 8'($urandom_range(0, 255));
      total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL gap_ready cyc=%0d got=%b want=1", cyc, bus.in_ready); end
      if (v[0]) begin
        exp_q.push_back(8'(100 + mcount));
        mcount++;
      end
      tick;
      cyc++;
    end
    total++; if (mcount != N) begin bad++; $display("FAIL gap_budget got=%0d want=%0d", mcount, N); end
    // Further beats offered while full must be refused.
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hEE;
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL gap_17_ready got=%b want=0", bus.in_ready); end
    tick;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL gap_17_count got=%0d want=16", count); end
    total++; if (start !== 1'b1) begin bad++; $display("FAIL gap_start got=%b want=1", start); end
    bus.in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      total++; if (slot(i) !== e) begin bad++; $display("FAIL gap_slot%0d got=%h want=%h", i, slot(i), e); end
    end
  endtask

  // Continues from the KICK cycle left by test_gaps.
  task automatic test_timeout;
    int early = 0;
    tick;
    for (int k = 1; k < TMO; k++) begin
      tick;
      if (done !== 1'b0) early++;
    end
    total++; if (early != 0) begin bad++; $display("FAIL tmo_early got=%0d want=0", early); end
    tick;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL tmo_done got=%b want=1", done); end
    total++; if (err !== 1'b1) begin bad++; $display("FAIL tmo_err got=%b want=1", err); end
    total++; if (count !== 5'd16) begin bad++; $display("FAIL tmo_count got=%0d want=16", count); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    total++; if (err !== 1'b0) begin bad++; $display("FAIL tmo_clr_err got=%b want=0", err); end
  endtask

  task automatic test_commit;
    logic [7:0] vals [3] = '{8'd7, 8'd2, 8'd5};
    logic [WIDTH-1:0] e;
    logic [WIDTH-1:0] pad;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.in_data = vals[i];
      exp_q.push_back(vals[i]);
      tick;
    end
    bus.in_valid = 1'b0;
    commit = 1'b1;
    tick;
    commit = 1'b0;
    total++; if (count !== 5'd3) begin bad++; $display("FAIL cm_count got=%0d want=3", count); end
`ifdef SORT_LOADER_PAD_EN
    pad = 8'hFF;
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL cm_load_n got=%b want=0", load_n); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL cm_ready got=%b want=0", bus.in_ready); end
`else
    pad = 8'h00;
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL cm_load_n got=%b want=1", load_n); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL cm_ready got=%b want=1", bus.in_ready); end
`endif
    for (int i = 0; i < N; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : pad;
      total++; if (slot(i) !== e) begin bad++; $display("FAIL cm_slot%0d got=%h want=%h", i, slot(i), e); end
    end
    tick;
`ifdef SORT_LOADER_PAD_EN
    total++; if (start !== 1'b1) begin bad++; $display("FAIL cm_start got=%b want=1", start); end
    tick;
    sort_done = 1'b1;
    tick;
    sort_done = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL cm_done got=%b want=1", done); end
    total++; if (count !== 5'd3) begin bad++; $display("FAIL cm_done_count got=%0d want=3", count); end
`else
    total++; if (start !== 1'b0) begin bad++; $display("FAIL cm_start got=%b want=0", start); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL cm_load_n2 got=%b want=1", load_n); end
`endif
    do_reset;
  endtask

  task automatic test_simultaneous;
    logic [WIDTH-1:0] e;
    bus.in_valid = 1'b1;
    for (int i = 0; i < N - 1; i++) begin
      bus.in_data = 8'(i * 3 + 1);
      exp_q.push_back(8'(i * 3 + 1));
      tick;
    end
    bus.in_data = 8'hA5;
    exp_q.push_back(8'hA5);
    commit = 1'b1;
    tick;
    commit = 1'b0;
    bus.in_valid = 1'b0;
    total++; if (count !== 5'd16) begin bad++; $display("FAIL sim_count got=%0d want=16", count); end
    total++; if (load_n !== 1'b0) begin bad++; $display("FAIL sim_load_n got=%b want=0", load_n); end
    for (int i = 0; i < N; i++) begin
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      total++; if (slot(i) !== e) begin bad++; $display("FAIL sim_slot%0d got=%h want=%h", i, slot(i), e); end
    end
    tick;
    total++; if (load_n !== 1'b1 || start !== 1'b1) begin bad++; $display("FAIL sim_kick got=%b%b want=11", load_n, start); end
    tick;
    total++; if (load_n !== 1'b1 || start !== 1'b0) begin bad++; $display("FAIL sim_wait got=%b%b want=10", load_n, start); end
    // sort_done on the very first WAIT cycle gives minimum latency.
    sort_done = 1'b1;
    tick;
    sort_done = 1'b0;
    total++; if (done !== 1'b1) begin bad++; $display("FAIL sim_min_lat got=%b want=1", done); end
    clear = 1'b1;
    tick;
    clear = 1'b0;
  endtask

  task automatic test_reset_mid;
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.in_data = 8'(i + 1);
      tick;
    end
    bus.in_valid = 1'b0;
    tick;
    #2 rst = 1'b0;
    #1;
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rk_start got=%b want=0", start); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rk_ready got=%b want=1", bus.in_ready); end
    rst = 1'b1;
    tick;
    bus.in_valid = 1'b1;
    for (int i = 0; i < N; i++) begin
      bus.in_data = 8'(i + 1);
      tick;
    end
    bus.in_valid = 1'b0;
    repeat (5) tick;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rw_ready got=%b want=1", bus.in_ready); end
    total++; if (load_n !== 1'b1) begin bad++; $display("FAIL rw_load_n got=%b want=1", load_n); end
    total++; if (start !== 1'b0) begin bad++; $display("FAIL rw_start got=%b want=0", start); end
    total++; if (done !== 1'b0 || err !== 1'b0) begin bad++; $display("FAIL rw_done_err got=%b%b want=00", done, err); end
    total++; if (count !== '0) begin bad++; $display("FAIL rw_count got=%0d want=0", count); end
    total++; if (data_flat !== '0) begin bad++; $display("FAIL rw_data got=%h want=0", data_flat); end
    rst = 1'b1;
    tick;
  endtask

  initial begin
    test_reset;
    test_full_load;
    test_gaps;
    test_timeout;
    test_commit;
    test_simultaneous;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sort_loader.md
Name: sort_loader

Overview:
- Writer side of the bitonic sort engine's input array.
- Accepts WIDTH-bit values one at a time over a valid/ready stream, packs them into an N-entry parallel array, then drives the sorter's active-low load strobe and a single step pulse.
- Waits for the sorter's end signal, then reports completion.
- Sits between the switch/key front end (or a UART/host source) and the sorter.

Parameters:
- WIDTH, 8, bits per element.
- N, 16, number of elements; must be a power of two and at least 2.
- IDX_W, 4, index width; equals clog2(N).
- TIMEOUT, 1024, maximum cycles to wait for sort_done before flagging an error.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  loader can accept a beat.
- in_data  in  WIDTH  element value.
- commit  in  1  single-cycle pulse: finish the load early.
- clear  in  1  single-cycle pulse: return from DONE to IDLE.
- sort_done  in  1  sorter end signal, level.
- load_n  out  1  active-low strobe to the sorter's load/reset input.
- start  out  1  single-cycle sort step pulse.
- data_flat  out  N*WIDTH  slot i occupies bits [i*WIDTH +: WIDTH].
- count  out  IDX_W+1  number of elements accepted, 0..N.
- done  out  1  sort finished, result valid.
- err  out  1  timeout occurred in WAIT.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; all slots=0; count=0.
  - in_ready=1; load_n=1; start=0; done=0; err=0.
- All outputs are registered.
- States: IDLE, LOAD, KICK, WAIT, DONE.
- IDLE:
  - in_ready=1.
  - A beat transfers when in_valid & in_ready: slot[count] <= in_data, count <= count+1.
  - When the beat making count==N transfers, next state is LOAD and in_ready=0 the following cycle. No beat is accepted once count==N.
  - commit with count==0 is ignored.
  - commit with 0<count<N: see the optional feature.
  - commit and a beat in the same cycle: the beat is written first, then commit is evaluated with the updated count.
- LOAD: load_n=0 for exactly 1 cycle, in_ready=0, then KICK.
- KICK: start=1 for exactly 1 cycle, then WAIT. The timeout counter clears on entry to WAIT.
- WAIT:
  - Timeout counter increments every cycle.
  - sort_done=1 -> DONE with err=0.
  - Counter reaches TIMEOUT-1 without sort_done -> DONE with err=1.
  - sort_done high on the first WAIT cycle is accepted, so minimum latency is 1 cycle.
- DONE:
  - done=1; in_ready=0; data_flat and count hold.
  - clear -> IDLE: slots=0, count=0, done=0, err=0.
- clear is ignored in every state other than DONE.
- commit is ignored in every state other than IDLE.
- End-to-end latency: last beat accepted at cycle t -> load_n low at t+1 -> start high at t+2 -> earliest done=1 at t+4 (sort_done sampled at t+3).
- Reset mid-operation (any state): immediate return to reset values. Any in-flight beat is lost. start and load_n return to inactive asynchronously.
- count never wraps: it saturates at N by construction.

Optional Feature:
- Macro: SORT_LOADER_PAD_EN.
- Defined:
  - commit in IDLE with 0<count<N moves to LOAD.
  - Every unwritten slot (index >= count) is set to all-ones, {WIDTH{1'b1}}, so padding sorts to the high end.
  - count keeps the true number of accepted elements.
- Not defined:
  - commit is ignored entirely; a load proceeds only when count==N.
  - No padding logic is synthesised.

Test Plan:
- Full load: reset, stream 16 beats 9,4,5,2,3,1,6,7,0,8,10,12,11,13,15,14 with in_valid held -> in_ready low after the 16th beat; data_flat slot0=9, slot15=14; load_n low 1 cycle, then start high 1 cycle; count=16.
- Handshake gaps: toggle in_valid randomly over 16 beats -> only cycles with valid&ready write; slots are in order with no duplicates or drops; a 17th in_valid is never accepted.
- Completion and timeout:
  - Sort done: model raises sort_done 5 cycles after start -> done=1, err=0; clear -> done=0, count=0, all slots 0, in_ready=1.
  - Timeout: sort_done held low -> done=1 and err=1 exactly TIMEOUT cycles after entering WAIT.
- Early commit (run both ways):
  - With SORT_LOADER_PAD_EN: load 3 beats 7,2,5, then commit -> slots3..15=8'hFF, count=3, load/start sequence issued.
  - Without the macro: the same commit leaves state IDLE and in_ready=1.
- Simultaneous events and reset:
  - Beat and commit together at count=15 -> beat stored in slot15, count=16, LOAD entered once.
  - Assert rst mid-WAIT -> all outputs return to reset values within the same cycle.
